// File: rtl/wb_src_sel.sv
// Register-writeback source selector: registered mux of NSRC sources with a
// wait state for the late-arriving memory source (timeout and flush abort).
module wb_src_sel #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 4,
  parameter int SELW    = 2,
  parameter int REGW    = 3,
  parameter int MEM_SRC = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [SELW-1:0]       sel,
  input  logic                  req_valid,
  input  logic [REGW-1:0]       req_dst,
  input  logic                  req_wen,
  input  logic                  mem_valid,
  input  logic                  flush,
  output logic                  busy,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REGW-1:0]       wb_dst,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  wb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [REGW-1:0] lat_dst, lat_dst_nx;
  logic            lat_wen, lat_wen_nx;

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] mem_data;
  logic             is_mem;

  logic             strobe;
  logic             s_we;
  logic             s_err;
  logic [WIDTH-1:0] s_data;
  logic [REGW-1:0]  s_dst;

  // Out-of-range selects fall through to source 0.
  always_comb begin
    sel_data = src_bus[0 +: WIDTH];
    for (int i = 0; i < NSRC; i++) begin
      if (int'(sel) == i) sel_data = src_bus[i*WIDTH +: WIDTH];
    end
  end

  assign mem_data = src_bus[MEM_SRC*WIDTH +: WIDTH];
  assign is_mem   = (int'(sel) == MEM_SRC);

  // Handshake: busy is the only back-pressure. A request (req_valid=1) is
  // taken on any non-flush cycle with busy=0; while busy=1 upstream holds it
  // and it is taken in the first cycle after busy falls.
  assign busy = (state == WAIT_MEM);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lat_dst_nx = lat_dst;
    lat_wen_nx = lat_wen;
    strobe     = 1'b0;
    s_we       = 1'b0;
    s_err      = 1'b0;
    s_data     = wb_data;
    s_dst      = wb_dst;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (is_mem && !mem_valid) begin
              state_nx   = WAIT_MEM;
              cnt_nx     = '0;
              lat_dst_nx = req_dst;
              lat_wen_nx = req_wen;
            end else begin
              strobe = 1'b1;
              s_data = sel_data;
              s_dst  = req_dst;
              s_we   = req_wen;
            end
          end
        end
        WAIT_MEM: begin
          cnt_nx = cnt + CW'(1);
          if (mem_valid) begin
            strobe   = 1'b1;
            s_data   = mem_data;
            s_dst    = lat_dst;
            s_we     = lat_wen;
            state_nx = IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            strobe   = 1'b1;
            s_data   = '0;
            s_dst    = lat_dst;
            s_err    = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_dst  <= '0;
      lat_wen  <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_err   <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lat_dst  <= lat_dst_nx;
      lat_wen  <= lat_wen_nx;
      wb_valid <= strobe;
      wb_we    <= s_we;
      wb_err   <= s_err;
      wb_dst   <= s_dst;
      wb_data  <= s_data;
    end
  end

endmodule

// File: tb/tb_wb_src_sel.sv
// Bench for wb_src_sel: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the writeback rules.
module tb_wb_src_sel;

  localparam int W  = 16;
  localparam int N  = 5;
  localparam int SW = 3;
  localparam int RW = 3;
  localparam int MS = 1;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*W-1:0]  src_bus;
  logic [W-1:0]    srcs [N];
  logic [SW-1:0]   sel = '0;
  logic            req_valid = 1'b0;
  logic [RW-1:0]   req_dst = '0;
  logic            req_wen = 1'b0;
  logic            mem_valid = 1'b0;
  logic            flush = 1'b0;
  logic            busy;
  logic            wb_valid;
  logic            wb_we;
  logic [RW-1:0]   wb_dst;
  logic [W-1:0]    wb_data;
  logic            wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit           m_wait;
  int           m_waited;
  logic [RW-1:0] m_dst;
  logic         m_wen;
  logic         e_valid, e_we, e_err;
  logic [RW-1:0] e_dst;
  logic [W-1:0] e_data;

  wb_src_sel #(
    .WIDTH(W), .NSRC(N), .SELW(SW), .REGW(RW), .MEM_SRC(MS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_bus(src_bus), .sel(sel),
    .req_valid(req_valid), .req_dst(req_dst), .req_wen(req_wen),
    .mem_valid(mem_valid), .flush(flush), .busy(busy), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_bus = '0;
    for (int i = 0; i < N; i++) src_bus[i*W +: W] = srcs[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_waited = 0; m_dst = '0; m_wen = 1'b0;
    e_valid = 0; e_we = 0; e_err = 0; e_dst = '0; e_data = '0;
  endtask

  task automatic model_emit(input logic [W-1:0] d, input logic [RW-1:0] dst,
                            input logic we, input logic err);
    e_valid = 1'b1; e_data = d; e_dst = dst; e_we = we; e_err = err;
  endtask

  // Evaluates the writeback rules on the inputs present before the next edge.
  task automatic model_step();
    e_valid = 1'b0; e_we = 1'b0; e_err = 1'b0;
    if (flush) begin
      m_wait = 0;
    end else if (!m_wait) begin
      if (req_valid) begin
        if (int'(sel) == MS && !mem_valid) begin
          m_wait = 1; m_waited = 0; m_dst = req_dst; m_wen = req_wen;
        end else begin
          model_emit((int'(sel) < N) ? srcs[sel] : srcs[0], req_dst, req_wen, 1'b0);
        end
      end
    end else begin
      m_waited++;
      if (mem_valid) begin
        model_emit(srcs[MS], m_dst, m_wen, 1'b0);
        m_wait = 0;
      end else if (m_waited == TO) begin
        model_emit('0, m_dst, 1'b0, 1'b1);
        m_wait = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, wb_valid, e_valid);
    check({tag, ".busy"},  busy, m_wait);
    check({tag, ".data"},  wb_data, e_data);
    check({tag, ".dst"},   wb_dst, e_dst);
    if (e_valid) begin
      check({tag, ".we"},  wb_we, e_we);
      check({tag, ".err"}, wb_err, e_err);
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic req(input logic [SW-1:0] s, input logic [RW-1:0] d, input logic w);
    req_valid = 1'b1; sel = s; req_dst = d; req_wen = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, wb_valid, 0);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".we"},    wb_we, 0);
    check({tag, ".err"},   wb_err, 0);
    check({tag, ".dst"},   wb_dst, 0);
    check({tag, ".data"},  wb_data, 0);
  endtask

  initial begin
    int busy_n;
    int guard;
    for (int i = 0; i < N; i++) srcs[i] = W'(16'h1000 + i);
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #2;

    // 1: plain select with one-cycle latency
    srcs[0] = 16'h1234;
    req(3'd0, 3'd3, 1'b1);
    cycle("t1");
    req_valid = 1'b0;
    cycle("t1_idle");

    // 2: memory source arrives after five busy cycles
    srcs[1] = 16'hBEEF;
    req(3'd1, 3'd5, 1'b1);
    cycle("t2_accept");
    busy_n = int'(busy);
    req(3'd2, 3'd7, 1'b0);
    req_valid = 1'b0;
    repeat (4) begin
      cycle("t2_wait");
      busy_n += int'(busy);
    end
    mem_valid = 1'b1;
    cycle("t2_done");
    check("t2_busy_cycles", busy_n, 5);
    check("t2_data", wb_data, 16'hBEEF);
    check("t2_dst", wb_dst, 3'd5);
    mem_valid = 1'b0;
    cycle("t2_idle");

    // 3: timeout after TO wait cycles
    req(3'd1, 3'd6, 1'b1);
    cycle("t3_accept");
    req_valid = 1'b0;
    busy_n = int'(busy);
    guard = 0;
    while (!wb_valid && guard < 3 * TO) begin
      cycle("t3_wait");
      busy_n += int'(busy);
      guard++;
    end
    check("t3_strobe_seen", wb_valid, 1);
    check("t3_busy_cycles", busy_n, TO);
    check("t3_err", wb_err, 1);
    check("t3_we", wb_we, 0);
    check("t3_data", wb_data, 0);
    cycle("t3_idle");

    // 4: flush beats mem_valid, then a normal request
    req(3'd1, 3'd2, 1'b1);
    cycle("t4_accept");
    req_valid = 1'b0;
    cycle("t4_wait");
    flush = 1'b1; mem_valid = 1'b1;
    cycle("t4_flush");
    check("t4_no_strobe", wb_valid, 0);
    flush = 1'b0; mem_valid = 1'b0;
    srcs[3] = 16'hC0DE;
    req(3'd3, 3'd4, 1'b1);
    cycle("t4_src3");
    check("t4_src3_data", wb_data, 16'hC0DE);
    req_valid = 1'b0;

    // 5: back-to-back strobes and out-of-range select
    srcs[2] = 16'h2222;
    req(3'd2, 3'd1, 1'b1);
    cycle("t5_src2");
    req(3'd3, 3'd2, 1'b0);
    cycle("t5_src3");
    req(3'd7, 3'd3, 1'b1);
    cycle("t5_oor");
    check("t5_oor_data", wb_data, 16'h1234);
    req_valid = 1'b0;
    cycle("t5_idle");

    // 6: asynchronous reset in the middle of a wait
    req(3'd1, 3'd7, 1'b1);
    cycle("t6_accept");
    req_valid = 1'b0;
    cycle("t6_wait");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("t6_async");
    mem_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    repeat (3) cycle("t6_after");
    mem_valid = 1'b0;

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) srcs[i] = W'($urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) sel = SW'(MS);
      req_dst   = RW'($urandom);
      req_wen   = 1'($urandom);
      mem_valid = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
